// File: rtl/stream_arb_mux_if.sv
// stream_arb_mux_if: bundles the N-input valid/ready streams and the single registered output stream
interface stream_arb_mux_if #(
    parameter int CHANNEL_BITS = 2,
    parameter int WIDTH = 16
);
    localparam int N = 2 ** CHANNEL_BITS;
    logic [N-1:0] in_valid;
    logic [N-1:0][WIDTH-1:0] in_data;
    logic [N-1:0] in_last;
    logic [N-1:0] in_ready;
    logic out_valid;
    logic [WIDTH-1:0] out_data;
    logic out_last;
    logic [CHANNEL_BITS-1:0] out_sel;
    logic out_ready;
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input in_ready, out_valid, out_data, out_last, out_sel
    );
    modport slave (
        input in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sel
    );
endinterface

// File: rtl/stream_arb_mux.sv
// stream_arb_mux: round-robin or fixed-priority packet arbiter feeding one registered output stage
module stream_arb_mux #(
    parameter int CHANNEL_BITS = 2,
    parameter int WIDTH = 16,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input logic clk,
    input logic rst_n,
    stream_arb_mux_if.slave bus
);
    localparam int N = 2 ** CHANNEL_BITS;
    logic locked;
    logic [CHANNEL_BITS-1:0] lock_ch;
    logic [CHANNEL_BITS-1:0] rr_ptr;
    logic [CHANNEL_BITS-1:0] grant;
    logic [CHANNEL_BITS-1:0] idx;
    logic grant_vld;
    logic load_en;
    logic accept;
    assign load_en = !bus.out_valid || bus.out_ready;
    // Scan from the highest search offset down so the first eligible index in search order wins; a held lock makes only lock_ch eligible
    always_comb begin
        grant = '0;
        grant_vld = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = ROUND_ROBIN ? rr_ptr + CHANNEL_BITS'(i) : CHANNEL_BITS'(i);
            if (locked ? (idx == lock_ch) : bus.in_valid[idx]) begin
                grant = idx;
                grant_vld = 1'b1;
            end
        end
    end
    assign bus.in_ready = (rst_n && load_en && grant_vld) ? (N'(1) << grant) : '0;
    assign accept = rst_n && load_en && grant_vld && bus.in_valid[grant];
    // Output register refills on the drain edge; lock and rotation pointer follow packet boundaries
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data <= {WIDTH{1'b0}};
            bus.out_last <= 1'b0;
            bus.out_sel <= '0;
            locked <= 1'b0;
            lock_ch <= '0;
            rr_ptr <= '0;
        end else begin
            if (load_en)
                bus.out_valid <= accept;
            if (accept) begin
                bus.out_data <= bus.in_data[grant];
                bus.out_last <= bus.in_last[grant];
                bus.out_sel <= grant;
                locked <= !bus.in_last[grant];
                if (!bus.in_last[grant])
                    lock_ch <= grant;
                else
                    rr_ptr <= grant + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_stream_arb_mux.sv
// tb_stream_arb_mux: directed scenarios plus random traffic against a behavioural arbiter model
module tb_stream_arb_mux;
    localparam int CB = 2;
    localparam int W = 8;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] in_valid = '0;
    logic [N-1:0][W-1:0] in_data = '0;
    logic [N-1:0] in_last = '0;
    logic out_ready = 1'b1;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    stream_arb_mux_if #(.CHANNEL_BITS(CB), .WIDTH(W)) bus_rr ();
    stream_arb_mux_if #(.CHANNEL_BITS(CB), .WIDTH(W)) bus_fp ();

    assign bus_rr.in_valid = in_valid;
    assign bus_rr.in_data = in_data;
    assign bus_rr.in_last = in_last;
    assign bus_rr.out_ready = out_ready;
    assign bus_fp.in_valid = in_valid;
    assign bus_fp.in_data = in_data;
    assign bus_fp.in_last = in_last;
    assign bus_fp.out_ready = out_ready;

    stream_arb_mux #(.CHANNEL_BITS(CB), .WIDTH(W), .ROUND_ROBIN(1'b1)) u_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr));
    stream_arb_mux #(.CHANNEL_BITS(CB), .WIDTH(W), .ROUND_ROBIN(1'b0)) u_fp (.clk(clk), .rst_n(rst_n), .bus(bus_fp));

    logic [N-1:0] d_rdy [2];
    logic d_ov [2];
    logic [W-1:0] d_od [2];
    logic d_ol [2];
    logic [CB-1:0] d_os [2];
    assign d_rdy[0] = bus_rr.in_ready;
    assign d_ov[0] = bus_rr.out_valid;
    assign d_od[0] = bus_rr.out_data;
    assign d_ol[0] = bus_rr.out_last;
    assign d_os[0] = bus_rr.out_sel;
    assign d_rdy[1] = bus_fp.in_ready;
    assign d_ov[1] = bus_fp.out_valid;
    assign d_od[1] = bus_fp.out_data;
    assign d_ol[1] = bus_fp.out_last;
    assign d_os[1] = bus_fp.out_sel;

    // behavioural model, index 0 = round-robin, 1 = fixed priority
    bit m_locked [2];
    int m_lock_ch [2];
    int m_rr [2];
    bit m_ov [2];
    int m_od [2];
    bit m_ol [2];
    int m_os [2];

    function automatic int m_grant(int m);
        if (m_locked[m]) return m_lock_ch[m];
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m == 0) ? (m_rr[m] + k) % N : k;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready(int m);
        int g;
        g = m_grant(m);
        if (rst_n && (!m_ov[m] || out_ready) && g >= 0) return N'(1) << g;
        return '0;
    endfunction

    function automatic void m_update(int m);
        int g;
        bit le;
        bit acc;
        if (!rst_n) begin
            m_locked[m] = 0; m_lock_ch[m] = 0; m_rr[m] = 0;
            m_ov[m] = 0; m_od[m] = 0; m_ol[m] = 0; m_os[m] = 0;
            return;
        end
        g = m_grant(m);
        le = !m_ov[m] || out_ready;
        acc = le && g >= 0 && in_valid[g];
        if (le) m_ov[m] = acc;
        if (acc) begin
            m_od[m] = int'(in_data[g]);
            m_ol[m] = in_last[g];
            m_os[m] = g;
            m_locked[m] = !in_last[g];
            if (!in_last[g]) m_lock_ch[m] = g;
            else m_rr[m] = (g + 1) % N;
        end
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        out_ready = 1'b1;
        in_valid = 4'b1111;
        in_last = 4'b1111;
        for (int i = 0; i < N; i++) in_data[i] = 8'h50 + 8'(i);
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (bus_rr.in_ready !== 4'b0000 || bus_fp.in_ready !== 4'b0000) begin
                bad++;
                $display("FAIL reset_in_ready cyc%0d: rr=%b fp=%b want 0000", c, bus_rr.in_ready, bus_fp.in_ready);
            end
            total++;
            if (bus_rr.out_valid !== 1'b0 || bus_rr.out_data !== 8'h00 || bus_fp.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_out cyc%0d: valid=%b data=%h want 0/00", c, bus_rr.out_valid, bus_rr.out_data);
            end
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (bus_rr.in_ready !== 4'b0001) begin
            bad++;
            $display("FAIL reset_release_grant: in_ready=%b want 0001", bus_rr.in_ready);
        end
        tick();
        total++;
        if (bus_rr.out_valid !== 1'b1 || bus_rr.out_data !== 8'h50 || bus_rr.out_sel !== 2'd0) begin
            bad++;
            $display("FAIL reset_first_beat: valid=%b data=%h sel=%0d want 1/50/0", bus_rr.out_valid, bus_rr.out_data, bus_rr.out_sel);
        end
    endtask

    task automatic test_round_robin;
        in_valid = 4'b1111;
        in_last = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_data[i] = 8'hA0 + 8'(i);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (bus_rr.out_valid !== 1'b1 || bus_rr.out_data !== 8'hA0 + 8'(k % N) || bus_rr.out_sel !== 2'(k % N)) begin
                bad++;
                $display("FAIL rr_seq beat%0d: valid=%b data=%h sel=%0d want 1/%h/%0d", k, bus_rr.out_valid, bus_rr.out_data, bus_rr.out_sel, 8'hA0 + 8'(k % N), k % N);
            end
        end
    endtask

    task automatic test_packet_lock;
        logic [W-1:0] exp_d [4];
        logic [CB-1:0] exp_s [4];
        exp_d = '{8'h11, 8'h12, 8'h13, 8'h05};
        exp_s = '{2'd1, 2'd1, 2'd1, 2'd0};
        out_ready = 1'b1;
        in_valid = 4'b0010;
        in_data[0] = 8'h05; in_last[0] = 1'b1;
        in_data[1] = 8'h11; in_last[1] = 1'b0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (bus_rr.out_valid !== 1'b1 || bus_rr.out_data !== exp_d[k] || bus_rr.out_sel !== exp_s[k]) begin
                bad++;
                $display("FAIL lock_seq beat%0d: valid=%b data=%h sel=%0d want 1/%h/%0d", k, bus_rr.out_valid, bus_rr.out_data, bus_rr.out_sel, exp_d[k], exp_s[k]);
            end
            if (k == 0) begin in_valid = 4'b0011; in_data[1] = 8'h12; end
            if (k == 1) begin in_data[1] = 8'h13; in_last[1] = 1'b1; end
            if (k == 2) in_valid = 4'b0001;
            if (k < 2) begin
                #1;
                total++;
                if (bus_rr.in_ready[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL lock_ch0_blocked beat%0d: in_ready=%b want bit0=0", k, bus_rr.in_ready);
                end
            end
        end
        // stall variant: channel 1 drops valid mid-packet
        in_valid = 4'b0010;
        in_data[1] = 8'h11; in_last[1] = 1'b0;
        do_reset();
        tick();
        in_valid = 4'b0001;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++;
            if (bus_rr.in_ready[0] !== 1'b0) begin
                bad++;
                $display("FAIL stall_ch0_blocked cyc%0d: in_ready=%b want bit0=0", k, bus_rr.in_ready);
            end
            tick();
            total++;
            if (bus_rr.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL stall_bubble cyc%0d: out_valid=%b want 0", k, bus_rr.out_valid);
            end
        end
        in_valid = 4'b0011;
        in_data[1] = 8'h12; in_last[1] = 1'b1;
        tick();
        total++;
        if (bus_rr.out_valid !== 1'b1 || bus_rr.out_data !== 8'h12 || bus_rr.out_sel !== 2'd1) begin
            bad++;
            $display("FAIL stall_resume: valid=%b data=%h sel=%0d want 1/12/1", bus_rr.out_valid, bus_rr.out_data, bus_rr.out_sel);
        end
        in_valid = 4'b0001;
        tick();
        total++;
        if (bus_rr.out_valid !== 1'b1 || bus_rr.out_data !== 8'h05 || bus_rr.out_sel !== 2'd0) begin
            bad++;
            $display("FAIL stall_after: valid=%b data=%h sel=%0d want 1/05/0", bus_rr.out_valid, bus_rr.out_data, bus_rr.out_sel);
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b1;
        in_valid = 4'b0001;
        in_last = 4'b1111;
        in_data[0] = 8'h42;
        do_reset();
        tick();
        out_ready = 1'b0;
        in_valid = 4'b1111;
        for (int i = 0; i < N; i++) in_data[i] = 8'h60 + 8'(i);
        for (int k = 0; k < 4; k++) begin
            #1;
            total++;
            if (bus_rr.in_ready !== 4'b0000) begin
                bad++;
                $display("FAIL bp_in_ready cyc%0d: in_ready=%b want 0000", k, bus_rr.in_ready);
            end
            tick();
            total++;
            if (bus_rr.out_valid !== 1'b1 || bus_rr.out_data !== 8'h42 || bus_rr.out_sel !== 2'd0) begin
                bad++;
                $display("FAIL bp_hold cyc%0d: valid=%b data=%h sel=%0d want 1/42/0", k, bus_rr.out_valid, bus_rr.out_data, bus_rr.out_sel);
            end
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (bus_rr.in_ready !== 4'b0010) begin
            bad++;
            $display("FAIL bp_release_ready: in_ready=%b want 0010", bus_rr.in_ready);
        end
        tick();
        total++;
        if (bus_rr.out_valid !== 1'b1 || bus_rr.out_data !== 8'h61 || bus_rr.out_sel !== 2'd1) begin
            bad++;
            $display("FAIL bp_no_bubble: valid=%b data=%h sel=%0d want 1/61/1", bus_rr.out_valid, bus_rr.out_data, bus_rr.out_sel);
        end
    endtask

    task automatic test_fixed_priority;
        out_ready = 1'b1;
        in_valid = 4'b1100;
        in_last = 4'b1111;
        in_data[2] = 8'h22;
        in_data[3] = 8'h33;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            #1;
            total++;
            if (bus_fp.in_ready !== 4'b0100) begin
                bad++;
                $display("FAIL fp_ready cyc%0d: in_ready=%b want 0100", k, bus_fp.in_ready);
            end
            tick();
            total++;
            if (bus_fp.out_valid !== 1'b1 || bus_fp.out_data !== 8'h22 || bus_fp.out_sel !== 2'd2) begin
                bad++;
                $display("FAIL fp_ch2 cyc%0d: valid=%b data=%h sel=%0d want 1/22/2", k, bus_fp.out_valid, bus_fp.out_data, bus_fp.out_sel);
            end
        end
        in_valid = 4'b1000;
        tick();
        total++;
        if (bus_fp.out_valid !== 1'b1 || bus_fp.out_data !== 8'h33 || bus_fp.out_sel !== 2'd3) begin
            bad++;
            $display("FAIL fp_ch3: valid=%b data=%h sel=%0d want 1/33/3", bus_fp.out_valid, bus_fp.out_data, bus_fp.out_sel);
        end
    endtask

    task automatic test_reset_mid_packet;
        out_ready = 1'b1;
        in_valid = 4'b1000;
        in_data[3] = 8'h3A;
        in_last = 4'b0111;
        do_reset();
        tick();
        total++;
        if (bus_rr.out_valid !== 1'b1 || bus_rr.out_data !== 8'h3A || bus_rr.out_sel !== 2'd3) begin
            bad++;
            $display("FAIL rmp_lock_beat: valid=%b data=%h sel=%0d want 1/3a/3", bus_rr.out_valid, bus_rr.out_data, bus_rr.out_sel);
        end
        rst_n = 1'b0;
        in_valid = 4'b1001;
        in_data[0] = 8'h0C;
        #1;
        total++;
        if (bus_rr.in_ready !== 4'b0000) begin
            bad++;
            $display("FAIL rmp_ready_in_reset: in_ready=%b want 0000", bus_rr.in_ready);
        end
        tick();
        total++;
        if (bus_rr.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rmp_out_cleared: out_valid=%b want 0", bus_rr.out_valid);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (bus_rr.in_ready !== 4'b0001) begin
            bad++;
            $display("FAIL rmp_lock_cleared: in_ready=%b want 0001", bus_rr.in_ready);
        end
        tick();
        total++;
        if (bus_rr.out_valid !== 1'b1 || bus_rr.out_data !== 8'h0C || bus_rr.out_sel !== 2'd0) begin
            bad++;
            $display("FAIL rmp_first_after: valid=%b data=%h sel=%0d want 1/0c/0", bus_rr.out_valid, bus_rr.out_data, bus_rr.out_sel);
        end
    endtask

    task automatic test_random;
        rst_n = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                logic [N-1:0] er;
                er = m_ready(m);
                total++;
                if (d_rdy[m] !== er) begin
                    bad++;
                    $display("FAIL rand_ready dut%0d cyc%0d: got %b want %b", m, i, d_rdy[m], er);
                end
                if (i > 0) begin
                    total++;
                    if (d_ov[m] !== m_ov[m] || (m_ov[m] && (d_od[m] !== W'(m_od[m]) || d_ol[m] !== m_ol[m] || d_os[m] !== CB'(m_os[m])))) begin
                        bad++;
                        $display("FAIL rand_out dut%0d cyc%0d: got v=%b d=%h l=%b s=%0d want v=%b d=%h l=%b s=%0d", m, i, d_ov[m], d_od[m], d_ol[m], d_os[m], m_ov[m], W'(m_od[m]), m_ol[m], m_os[m]);
                    end
                end
            end
            m_update(0);
            m_update(1);
            tick();
            rst_n = ($urandom_range(0, 99) != 0);
            in_valid = N'($urandom);
            in_last = N'($urandom);
            for (int c = 0; c < N; c++) in_data[c] = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_fixed_priority();
        test_reset_mid_packet();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stream_arb_mux.md
Name: stream_arb_mux

Overview:
- Parametrised, registered successor to the combinational generic multiplexer.
- Arbitrates among 2**CHANNEL_BITS valid/ready input streams and forwards one beat per cycle through a single output register.
- Selection is by round-robin or fixed priority, and a multi-beat packet holds the grant until its last beat.
- Used wherever several producers share one consumer, e.g. bus or writeback ports in the 16-bit datapath.

Parameters:
- CHANNEL_BITS, 2, select width; number of channels N = 2**CHANNEL_BITS (N >= 2).
- WIDTH, 16, data bits per beat.
- ROUND_ROBIN, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- in_valid  input  N  per-channel beat valid.
- in_data  input  N x WIDTH  packed per-channel data; channel i is in_data[i].
- in_last  input  N  per-channel last-beat-of-packet flag.
- in_ready  output  N  per-channel accept; at most one bit is high per cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data.
- out_last  output  1  registered last flag.
- out_sel  output  CHANNEL_BITS  index of the channel that sourced the current output beat.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, out_last=0, out_sel=0, locked=0, lock_ch=0, rr_ptr=0. Reset takes priority over all other actions; a packet in flight is dropped and the lock is cleared.
- in_ready is combinational and is low for the whole cycle while rst_n=0.
- load_en = !out_valid || out_ready. The output register refills in the same cycle it drains, giving full throughput.
- Eligibility:
  - locked=1: only lock_ch is eligible.
  - locked=0: every channel with in_valid=1 is eligible.
- Grant:
  - ROUND_ROBIN=1: search indices rr_ptr, rr_ptr+1, ... mod N; the first eligible index wins.
  - ROUND_ROBIN=0: the lowest eligible index wins.
  - No eligible channel: no grant.
- in_ready[g] = load_en && granted(g). All other in_ready bits are 0. No ready-to-valid dependency on the input side other than the grant.
- Accept = in_valid[g] && in_ready[g]. On accept, at the next edge:
  - out_data <= in_data[g], out_last <= in_last[g], out_sel <= g, out_valid <= 1.
- If load_en=1 and there is no accept, out_valid <= 0. out_data, out_last and out_sel hold their values; they are don't-care while out_valid=0.
- Stall: while out_valid=1 and out_ready=0, out_data, out_last and out_sel are held stable and every in_ready bit is 0.
- Latency: exactly one cycle from accept to out_valid.
- Lock:
  - An accepted beat with in_last=0 sets locked=1 and lock_ch=g.
  - An accepted beat with in_last=1 clears locked.
  - A locked channel that drops in_valid mid-packet keeps the lock; no other channel is granted and no beats are emitted until it resumes.
- rr_ptr: on an accepted beat with in_last=1, rr_ptr <= (g+1) mod N, wrapping from N-1 to 0. rr_ptr is unchanged otherwise. Single-beat packets therefore rotate every beat.
- In fixed-priority mode, rr_ptr is unused and the lock still applies.
- Simultaneous drain and refill from the same or a different channel in one cycle is legal and required.

Test Plan (CHANNEL_BITS=2, WIDTH=8):
- Reset: hold rst_n=0 for 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0x00. Release reset -> channel 0 granted first and out_data=in_data[0] one cycle later.
- Round-robin: all four channels valid with single-beat packets (last=1), data 0xA0..0xA3, out_ready=1 -> out_data sequence A0, A1, A2, A3, A0 on consecutive cycles; out_sel 0, 1, 2, 3, 0.
- Packet lock:
  - Stimulus: channel 1 sends 3 beats (0x11, 0x12, 0x13 with last on the third) while channel 0 is continuously valid (data 0x05, single-beat packets).
  - Required: output 0x11, 0x12, 0x13 uninterrupted, then 0x05.
  - Stall variant: drop channel 1's valid for 2 cycles mid-packet -> out_valid=0 for those cycles and channel 0 is not granted.
- Backpressure: out_ready=0 for 4 cycles with out_valid=1 and out_data=0x42 -> out_data stays 0x42 and in_ready=0000 throughout. Raise out_ready -> next beat loads on that same edge with no bubble.
- Fixed priority (ROUND_ROBIN=0): channels 2 and 3 continuously valid with single-beat packets -> channel 2 is granted every cycle and channel 3 never, until channel 2 deasserts.
- Reset mid-packet: assert rst_n=0 while locked on channel 3 -> locked=0 and out_valid=0 after the edge. The first packet after reset is taken from channel 0 if it is valid.
